// File: rtl/audio_receive.sv
// I2S capture receiver for the WM8978 ADC path: assembles left/right words from
// the serial stream and presents sign-extended stereo pairs with valid/ready.
module audio_receive #(
    parameter logic [5:0] WL = 6'd32
) (
    input  logic        aud_bclk,
    input  logic        rst,
    input  logic        aud_lrc,
    input  logic        aud_adcdat,
    output logic [31:0] adc_left,
    output logic [31:0] adc_right,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        rx_ovf,
    output logic        frame_err,
    input  logic        err_clr
);
    localparam int W = int'(WL);

    logic         aud_lrc_d0;
    logic [5:0]   rx_cnt;
    logic [W-1:0] shift_reg;
    logic [W-1:0] left_hold;
    logic [W-1:0] word;
    logic         left_ok;
    logic         lrc_edge;
    logic         capture;
    logic         commit;
    logic         short_frame;
    logic         publish;
    logic         accept;
    logic [31:0]  left_ext;
    logic [31:0]  right_ext;

    assign lrc_edge    = aud_lrc ^ aud_lrc_d0;
    assign capture     = rx_cnt < WL;
    assign commit      = rx_cnt == (WL - 6'd1);
    assign word        = {shift_reg[W-2:0], aud_adcdat};
    assign short_frame = lrc_edge && (rx_cnt < (WL - 6'd1));
    // aud_lrc_d0 still names the slot whose final bit is being sampled
    assign publish     = commit && aud_lrc_d0 && left_ok;
    assign accept      = rx_valid && rx_ready;

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_ext
            if (gi < W) begin : g_bit
                assign left_ext[gi]  = left_hold[gi];
                assign right_ext[gi] = word[gi];
            end else begin : g_sign
                assign left_ext[gi]  = left_hold[W-1];
                assign right_ext[gi] = word[W-1];
            end
        end
    endgenerate

    always_ff @(posedge aud_bclk) begin
        if (rst) begin
            aud_lrc_d0 <= 1'b0;
            rx_cnt     <= WL;
            shift_reg  <= '0;
            left_hold  <= '0;
            left_ok    <= 1'b0;
            adc_left   <= '0;
            adc_right  <= '0;
            rx_valid   <= 1'b0;
            rx_ovf     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            aud_lrc_d0 <= aud_lrc;

            // an LRC edge restarts the slot even when it also carries the last bit
            if (lrc_edge) begin
                rx_cnt    <= '0;
                shift_reg <= '0;
            end else if (capture) begin
                rx_cnt    <= rx_cnt + 6'd1;
                shift_reg <= word;
            end

            if (commit && !aud_lrc_d0) begin
                left_hold <= word;
                left_ok   <= 1'b1;
            end else if (commit || short_frame) begin
                left_ok   <= 1'b0;
            end

            if (publish) begin
                adc_left  <= left_ext;
                adc_right <= right_ext;
                rx_valid  <= 1'b1;
            end else if (accept) begin
                rx_valid  <= 1'b0;
            end

            if (publish && rx_valid && !rx_ready)
                rx_ovf <= 1'b1;
            else if (err_clr)
                rx_ovf <= 1'b0;

            if (short_frame)
                frame_err <= 1'b1;
            else if (err_clr)
                frame_err <= 1'b0;
        end
    end
endmodule
